// File: rtl/start_sequencer.sv
// start_sequencer: queues job tags in a small FIFO and launches them one at a
// time to a downstream busy counter. For each launched job it reports the tag
// and the number of cycles the busy flag stayed high.
module start_sequencer #(
    parameter int TAG_W   = 8,
    parameter int LGDEPTH = 2
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_req_valid,
    input  logic [TAG_W-1:0]   i_req_tag,
    output logic               o_req_ready,
    output logic               o_start,
    input  logic               i_busy,
    output logic               o_done_valid,
    output logic [TAG_W-1:0]   o_done_tag,
    output logic [15:0]        o_done_cycles,
    output logic [LGDEPTH:0]   o_pending
);

    localparam int               DEPTH = 1 << LGDEPTH;
    localparam logic [LGDEPTH:0] FULL  = (LGDEPTH+1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, RUN, DONE} state_t;

    state_t             state, state_nx;
    logic [TAG_W-1:0]   mem [DEPTH];
    logic [LGDEPTH-1:0] wr_ptr, rd_ptr;
    logic [LGDEPTH:0]   count;
    logic [TAG_W-1:0]   cur_tag;
    logic [15:0]        cycles;
    logic               push, pop;

    // Ready depends on the registered count only, so a same-cycle pop never
    // opens a slot in a full FIFO.
    assign o_req_ready = (count != FULL);
    assign o_pending   = count;
    assign push        = i_req_valid && o_req_ready;
    // A launch is only allowed while idle and nothing downstream is busy,
    // including a busy period that was started by someone else.
    assign pop         = (state == IDLE) && (count != '0) && !i_busy;

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_nx;
    end

    // Next-state logic for the launch / measure / report sequence
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pop) state_nx = LAUNCH;
            LAUNCH:  state_nx = WAIT;
            WAIT:    state_nx = i_busy ? RUN : DONE;
            RUN:     if (!i_busy) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from the registered state, so they clear with reset
    always_comb begin
        o_start       = (state == LAUNCH);
        o_done_valid  = (state == DONE);
        o_done_tag    = (state == DONE) ? cur_tag : '0;
        o_done_cycles = (state == DONE) ? cycles  : '0;
    end

    // FIFO storage; contents are qualified by the pointers and need no reset
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= i_req_tag;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Current job tag and saturating busy-cycle counter
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cur_tag <= '0;
            cycles  <= '0;
        end else begin
            if (pop) cur_tag <= mem[rd_ptr];
            case (state)
                LAUNCH:  cycles <= '0;
                WAIT:    cycles <= i_busy ? 16'd1 : 16'd0;
                RUN:     if (i_busy && cycles != '1) cycles <= cycles + 16'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_start_sequencer.sv
// tb_start_sequencer: directed scenarios plus a randomized run against a
// timestamp-based reference model of the start sequencer.
module tb_start_sequencer;

    logic        clk = 1'b0;
    logic        i_reset_n;
    logic        i_req_valid;
    logic [7:0]  i_req_tag;
    logic        i_busy;
    logic        o_req_ready;
    logic        o_start;
    logic        o_done_valid;
    logic [7:0]  o_done_tag;
    logic [15:0] o_done_cycles;
    logic [2:0]  o_pending;

    start_sequencer #(.TAG_W(8), .LGDEPTH(2)) dut (
        .i_clk         (clk),
        .i_reset_n     (i_reset_n),
        .i_req_valid   (i_req_valid),
        .i_req_tag     (i_req_tag),
        .o_req_ready   (o_req_ready),
        .o_start       (o_start),
        .i_busy        (i_busy),
        .o_done_valid  (o_done_valid),
        .o_done_tag    (o_done_tag),
        .o_done_cycles (o_done_cycles),
        .o_pending     (o_pending)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Downstream busy counter emulation plus an external busy source
    logic ext_busy;
    int   rem;
    int   next_len;

    // Outputs sampled at the falling edge of the current cycle
    logic        ob_ready, ob_start, ob_done;
    logic [7:0]  ob_tag;
    logic [15:0] ob_cyc;
    logic [2:0]  ob_pend;

    // Reference model: tag queue plus timestamps of the in-flight job
    logic [7:0]  mq[$];
    bit          m_job, m_ended;
    int          m_launch, m_done_at, m_cnt;
    logic [7:0]  m_tag;
    int          cyc = 0;
    logic        ex_ready, ex_start, ex_done;
    logic [7:0]  ex_tag;
    logic [15:0] ex_cyc;
    logic [2:0]  ex_pend;

    task automatic model_reset();
        mq.delete();
        m_job   = 0;
        m_ended = 0;
        m_cnt   = 0;
    endtask

    // Expected outputs for this cycle, then advance by this cycle's inputs
    task automatic model_cycle();
        int sz;
        if (!i_reset_n) begin
            model_reset();
            {ex_ready, ex_start, ex_done, ex_tag, ex_cyc, ex_pend} = {1'b1, 1'b0, 1'b0, 8'h00, 16'h0, 3'd0};
            return;
        end
        sz       = mq.size();
        ex_ready = (sz < 4);
        ex_pend  = 3'(sz);
        ex_start = m_job && (cyc == m_launch);
        ex_done  = m_job && m_ended && (cyc == m_done_at);
        ex_tag   = ex_done ? m_tag : 8'h00;
        ex_cyc   = ex_done ? 16'(m_cnt) : 16'h0;
        if (ex_done) begin
            m_job = 0;
        end else if (m_job && !m_ended && cyc > m_launch) begin
            if (i_busy) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
            else begin
                m_ended   = 1;
                m_done_at = cyc + 1;
            end
        end else if (!m_job && sz > 0 && !i_busy) begin
            m_tag    = mq.pop_front();
            m_job    = 1;
            m_ended  = 0;
            m_launch = cyc + 1;
            m_cnt    = 0;
        end
        if (i_req_valid && sz < 4) mq.push_back(i_req_tag);
    endtask

    // One clock cycle: drive busy, sample outputs, step the model
    task automatic tick();
        i_busy = ext_busy | (rem != 0);
        if (rem != 0) rem--;
        @(negedge clk);
        ob_ready = o_req_ready;
        ob_start = o_start;
        ob_done  = o_done_valid;
        ob_tag   = o_done_tag;
        ob_cyc   = o_done_cycles;
        ob_pend  = o_pending;
        model_cycle();
        if (ob_start) rem = next_len;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        i_req_valid = 1'b0;
        ext_busy    = 1'b0;
        for (int k = 0; k < 300 && (mq.size() != 0 || m_job); k++) tick();
    endtask

    task automatic test_reset();
        i_reset_n   = 1'b0;
        i_req_valid = 1'b0;
        i_req_tag   = 8'h00;
        i_busy      = 1'b0;
        ext_busy    = 1'b0;
        rem         = 0;
        next_len    = 0;
        model_reset();
        #1;
        n_cmp++;
        if ({o_start, o_done_valid, o_done_tag, o_done_cycles, o_pending, o_req_ready} !==
            {1'b0, 1'b0, 8'h00, 16'h0, 3'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_outputs: got start=%b done=%b tag=%h cyc=%0d pend=%0d rdy=%b want 0 0 00 0 0 1",
                     o_start, o_done_valid, o_done_tag, o_done_cycles, o_pending, o_req_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        i_reset_n = 1'b1;
    endtask

    task automatic test_single();
        int st = -1, dn = -1, fall = -1;
        bit hi = 0;
        logic [7:0]  dtag = 8'h00;
        logic [15:0] dcyc = 16'h0;
        next_len = 21;
        for (int k = 0; k < 60 && dn < 0; k++) begin
            i_req_valid = (k == 0);
            i_req_tag   = 8'h11;
            tick();
            if (ob_start && st < 0) st = k;
            if (i_busy) hi = 1;
            else if (hi && fall < 0) fall = k;
            if (ob_done) begin
                dn   = k;
                dtag = ob_tag;
                dcyc = ob_cyc;
            end
        end
        i_req_valid = 1'b0;
        n_cmp++;
        if (st !== 2) begin n_bad++; $display("FAIL single_start_cycle: got %0d want 2", st); end
        n_cmp++;
        if (dn !== 25) begin n_bad++; $display("FAIL single_done_cycle: got %0d want 25", dn); end
        n_cmp++;
        if (dtag !== 8'h11) begin n_bad++; $display("FAIL single_done_tag: got %h want 11", dtag); end
        n_cmp++;
        if (dcyc !== 16'd21) begin n_bad++; $display("FAIL single_done_cycles: got %0d want 21", dcyc); end
        n_cmp++;
        if (dn !== fall + 1) begin n_bad++; $display("FAIL single_done_after_fall: got %0d want %0d", dn, fall + 1); end
    endtask

    task automatic test_zero_len();
        int sk[2], dk[2], ns = 0, nd = 0;
        logic [7:0]  dt[2];
        logic [15:0] dc[2];
        drain();
        next_len = 0;
        for (int k = 0; k < 30; k++) begin
            i_req_valid = (k < 2);
            i_req_tag   = (k == 0) ? 8'hA1 : 8'hA2;
            tick();
            if (ob_start && ns < 2) begin sk[ns] = k; ns++; end
            if (ob_done && nd < 2) begin dk[nd] = k; dt[nd] = ob_tag; dc[nd] = ob_cyc; nd++; end
        end
        i_req_valid = 1'b0;
        n_cmp++;
        if (ns != 2 || sk[0] != 2 || sk[1] != 6) begin
            n_bad++; $display("FAIL zero_len_starts: got n=%0d at %0d,%0d want 2 at 2,6", ns, sk[0], sk[1]);
        end
        n_cmp++;
        if (nd != 2 || dk[0] != 4 || dt[0] !== 8'hA1 || dc[0] !== 16'd0) begin
            n_bad++; $display("FAIL zero_len_done0: got n=%0d k=%0d tag=%h cyc=%0d want k=4 tag=a1 cyc=0", nd, dk[0], dt[0], dc[0]);
        end
        n_cmp++;
        if (nd != 2 || dk[1] != 8 || dt[1] !== 8'hA2 || dc[1] !== 16'd0) begin
            n_bad++; $display("FAIL zero_len_done1: got n=%0d k=%0d tag=%h cyc=%0d want k=8 tag=a2 cyc=0", nd, dk[1], dt[1], dc[1]);
        end
    endtask

    task automatic test_ext_busy();
        int st = -1, bad_st = 0, nd = 0;
        logic [7:0]  dtag = 8'h00;
        logic [15:0] dcyc = 16'h0;
        drain();
        next_len = 3;
        for (int k = 0; k < 30; k++) begin
            ext_busy    = (k < 10);
            i_req_valid = (k == 0);
            i_req_tag   = 8'h5A;
            tick();
            if (ob_start && i_busy) bad_st++;
            if (ob_start && st < 0) st = k;
            if (ob_done) begin nd++; dtag = ob_tag; dcyc = ob_cyc; end
        end
        i_req_valid = 1'b0;
        ext_busy    = 1'b0;
        n_cmp++;
        if (st !== 11) begin n_bad++; $display("FAIL ext_busy_start_cycle: got %0d want 11", st); end
        n_cmp++;
        if (bad_st !== 0) begin n_bad++; $display("FAIL ext_busy_start_while_busy: got %0d want 0", bad_st); end
        n_cmp++;
        if (nd !== 1 || dtag !== 8'h5A || dcyc !== 16'd3) begin
            n_bad++; $display("FAIL ext_busy_done: got n=%0d tag=%h cyc=%0d want n=1 tag=5a cyc=3", nd, dtag, dcyc);
        end
    endtask

    task automatic test_fifo_full();
        int acc = 0;
        drain();
        ext_busy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            i_req_valid = 1'b1;
            i_req_tag   = 8'h30 + 8'(k);
            tick();
            if (ob_ready) acc++;
            if (k >= 4) begin
                n_cmp++;
                if ({ob_ready, ob_pend} !== {1'b0, 3'd4}) begin
                    n_bad++; $display("FAIL full_ready_pending k=%0d: got rdy=%b pend=%0d want 0 4", k, ob_ready, ob_pend);
                end
            end
        end
        i_req_valid = 1'b0;
        n_cmp++;
        if (acc !== 4) begin n_bad++; $display("FAIL full_accepted: got %0d want 4", acc); end
    endtask

    task automatic test_full_pop_push();
        int nd = 0;
        logic [7:0] dt[$];
        next_len    = 2;
        ext_busy    = 1'b0;
        i_req_valid = 1'b1;
        i_req_tag   = 8'hEE;
        tick();
        n_cmp++;
        if ({ob_ready, ob_pend} !== {1'b0, 3'd4}) begin
            n_bad++; $display("FAIL pop_push_cycle: got rdy=%b pend=%0d want 0 4", ob_ready, ob_pend);
        end
        i_req_valid = 1'b0;
        tick();
        n_cmp++;
        if ({ob_start, ob_pend} !== {1'b1, 3'd3}) begin
            n_bad++; $display("FAIL pop_push_after: got start=%b pend=%0d want 1 3", ob_start, ob_pend);
        end
        for (int k = 0; k < 80; k++) begin
            tick();
            if (ob_done) begin nd++; dt.push_back(ob_tag); end
        end
        n_cmp++;
        if (nd !== 4) begin n_bad++; $display("FAIL full_done_count: got %0d want 4", nd); end
        for (int i = 0; i < 4 && i < dt.size(); i++) begin
            n_cmp++;
            if (dt[i] !== 8'h30 + 8'(i)) begin
                n_bad++; $display("FAIL full_done_order[%0d]: got %h want %h", i, dt[i], 8'h30 + 8'(i));
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int nd = 0, bad_pend = 0;
        drain();
        next_len = 50;
        for (int k = 0; k < 9; k++) begin
            i_req_valid = (k < 4);
            i_req_tag   = 8'h77 + 8'(k);
            tick();
        end
        i_req_valid = 1'b0;
        n_cmp++;
        if ({ob_pend, ob_done} !== {3'd3, 1'b0}) begin
            n_bad++; $display("FAIL mid_run_setup: got pend=%0d done=%b want 3 0", ob_pend, ob_done);
        end
        i_reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({o_start, o_done_valid, o_done_tag, o_done_cycles, o_pending, o_req_ready} !==
            {1'b0, 1'b0, 8'h00, 16'h0, 3'd0, 1'b1}) begin
            n_bad++; $display("FAIL mid_run_reset_outputs: got start=%b done=%b tag=%h cyc=%0d pend=%0d rdy=%b want 0 0 00 0 0 1",
                              o_start, o_done_valid, o_done_tag, o_done_cycles, o_pending, o_req_ready);
        end
        rem = 0;
        model_reset();
        tick();
        tick();
        i_reset_n = 1'b1;
        for (int k = 0; k < 70; k++) begin
            tick();
            if (ob_done) nd++;
            if (ob_pend != 3'd0) bad_pend++;
        end
        n_cmp++;
        if (nd !== 0) begin n_bad++; $display("FAIL mid_run_no_done: got %0d want 0", nd); end
        n_cmp++;
        if (bad_pend !== 0) begin n_bad++; $display("FAIL mid_run_pending: got %0d nonzero cycles want 0", bad_pend); end
    endtask

    task automatic test_random();
        drain();
        for (int k = 0; k < 600; k++) begin
            i_req_valid = ($urandom_range(0, 99) < 45);
            i_req_tag   = 8'($urandom);
            next_len    = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
            tick();
            n_cmp++;
            if ({ob_ready, ob_pend, ob_start, ob_done} !== {ex_ready, ex_pend, ex_start, ex_done}) begin
                n_bad++; $display("FAIL rand_ctrl cyc=%0d: got rdy=%b pend=%0d start=%b done=%b want %b %0d %b %b",
                                  cyc, ob_ready, ob_pend, ob_start, ob_done, ex_ready, ex_pend, ex_start, ex_done);
            end
            n_cmp++;
            if ({ob_tag, ob_cyc} !== {ex_tag, ex_cyc}) begin
                n_bad++; $display("FAIL rand_data cyc=%0d: got tag=%h cycles=%0d want %h %0d",
                                  cyc, ob_tag, ob_cyc, ex_tag, ex_cyc);
            end
        end
        i_req_valid = 1'b0;
    endtask

    task automatic test_saturate();
        bit got = 0;
        logic [7:0]  dtag = 8'h00;
        logic [15:0] dcyc = 16'h0;
        drain();
        next_len = 65537;
        for (int k = 0; k < 70000 && !got; k++) begin
            i_req_valid = (k == 0);
            i_req_tag   = 8'hC3;
            tick();
            if (ob_done) begin got = 1; dtag = ob_tag; dcyc = ob_cyc; end
        end
        i_req_valid = 1'b0;
        n_cmp++;
        if (!got || dtag !== 8'hC3 || dcyc !== 16'hFFFF) begin
            n_bad++; $display("FAIL saturate: got seen=%0d tag=%h cycles=%h want 1 c3 ffff", got, dtag, dcyc);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_len();
        test_ext_busy();
        test_fifo_full();
        test_full_pop_push();
        test_reset_mid_run();
        test_random();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
